// File: rtl/mul_add_seq.sv
// rtl/mul_add_seq.sv - iterative shift-add unsigned multiply-accumulate
//
// Purpose:
//   Computes product = multiplicand * multiplier + addend with a radix-2
//   shift-add loop. Exactly WIDTH iterations run per operation, so the
//   latency is fixed. Only one operation is in flight at a time.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operand set presented
//   in_ready     block can accept operands (IDLE only)
//   multiplicand unsigned operand A, WIDTH bits
//   multiplier   unsigned operand B, WIDTH bits
//   addend       unsigned operand C, WIDTH bits, zero-extended
//   out_valid    product valid (DONE only)
//   out_ready    consumer accepts product
//   product      A*B+C, 2*WIDTH bits, held stable while out_valid is high
//   busy         high while an operation is running or waiting for handoff

module mul_add_seq #(
   parameter int WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     addend,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t               state;
   state_t               state_nxt;

   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc_sum;

   logic                 accept;
   logic                 handoff;
   logic                 last_iter;

   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;
   assign last_iter = (state == S_RUN) && (cnt == CNT_LAST);

   // Max result is 2^(2W) - 2^W, so the 2W-bit sum never carries out.
   assign acc_sum = mplier[0] ? (acc + mcand) : acc;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  if (handoff)   state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; in_ready stays low on the handoff cycle
   // because the FSM is still in DONE then.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE:  in_ready  = 1'b1;
         S_RUN:   busy      = 1'b1;
         S_DONE:  begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: operands are latched on acceptance so the inputs may change
   // freely afterwards. No early exit when mplier reaches zero, which keeps
   // the latency independent of operand values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         acc     <= {{WIDTH{1'b0}}, addend};
         mcand   <= {{WIDTH{1'b0}}, multiplicand};
         mplier  <= multiplier;
         cnt     <= '0;
      end else if (state == S_RUN) begin
         acc     <= acc_sum;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt + CW'(1);
         if (last_iter) begin
            product <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_mul_add_seq.sv
// tb/tb_mul_add_seq.sv - directed and random checks for mul_add_seq

module tb_mul_add_seq;

   localparam int W = 10;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic [W-1:0]    addend;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  product;
   logic            busy;

   int n_cmp;
   int n_err;

   mul_add_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand set for a single edge (caller guarantees IDLE),
   // scrambles the inputs, then counts cycles until out_valid rises.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, output int lat,
                        output logic [2*W-1:0] prod);
      multiplicand = a;
      multiplier   = b;
      addend       = c;
      in_valid     = 1'b1;
      step();
      in_valid     = 1'b0;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      addend       = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      prod = product;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      addend       = '0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d: in_ready=%b out_valid=%b busy=%b product=%0d, need 1 0 0 0",
                     i, in_ready, out_valid, busy, product);
         end
      end
   endtask

   task automatic test_max();
      int lat;
      logic [2*W-1:0] p;
      out_ready = 1'b1;
      do_op(10'd1023, 10'd1023, 10'd1023, lat, p);
      n_cmp++;
      if (lat !== 10) begin
         n_err++;
         $display("FAIL max_latency: got %0d, need 10", lat);
      end
      n_cmp++;
      if (p !== 20'hFFC00) begin
         n_err++;
         $display("FAIL max_product: got %0d, need 1047552", p);
      end
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL max_done_flags: in_ready=%b busy=%b, need 0 1", in_ready, busy);
      end
      step();
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL max_back_idle: in_ready=%b out_valid=%b busy=%b, need 1 0 0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic test_zero();
      int lat;
      logic [2*W-1:0] p;
      out_ready = 1'b1;
      do_op(10'd0, 10'd517, 10'd5, lat, p);
      n_cmp++;
      if (lat !== 10 || p !== 20'd5) begin
         n_err++;
         $display("FAIL zero_a: latency=%0d product=%0d, need 10 5", lat, p);
      end
      step();
      do_op(10'd37, 10'd0, 10'd0, lat, p);
      n_cmp++;
      if (lat !== 10 || p !== 20'd0) begin
         n_err++;
         $display("FAIL zero_b: latency=%0d product=%0d, need 10 0", lat, p);
      end
      step();
   endtask

   task automatic test_roundtrip();
      int lat;
      logic [2*W-1:0] p;
      logic [W-1:0] a, b, c;
      logic [63:0] ref_val;
      int bad;
      out_ready = 1'b1;
      do_op(10'd7, 10'd100, 10'd3, lat, p);
      n_cmp++;
      if (lat !== 10 || p !== 20'd703) begin
         n_err++;
         $display("FAIL roundtrip_703: latency=%0d product=%0d, need 10 703", lat, p);
      end
      step();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom_range(0, 1023));
         b = W'($urandom_range(0, 1023));
         c = W'($urandom_range(0, 1023));
         ref_val = 64'(a) * 64'(b) + 64'(c);
         do_op(a, b, c, lat, p);
         n_cmp++;
         if (lat !== 10 || 64'(p) !== ref_val) begin
            n_err++;
            if (bad < 10)
               $display("FAIL sweep[%0d] %0d*%0d+%0d: latency=%0d product=%0d, need 10 %0d",
                        i, a, b, c, lat, p, ref_val);
            bad++;
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [2*W-1:0] p;
      out_ready = 1'b0;
      do_op(10'd25, 10'd40, 10'd9, lat, p);
      n_cmp++;
      if (lat !== 10 || p !== 20'd1009) begin
         n_err++;
         $display("FAIL bp_result: latency=%0d product=%0d, need 10 1009", lat, p);
      end
      for (int i = 0; i < 5; i++) begin
         multiplicand = 10'd1;
         multiplier   = 10'd1;
         addend       = 10'd1;
         in_valid     = 1'b1;
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || product !== 20'd1009 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold cyc=%0d: out_valid=%b product=%0d in_ready=%b, need 1 1009 0",
                     i, out_valid, product, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_handoff: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
      end
      for (int i = 0; i < 14; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_not_queued cyc=%0d: out_valid=%b busy=%b, need 0 0",
                     i, out_valid, busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [2*W-1:0] p;
      out_ready    = 1'b1;
      multiplicand = 10'd1023;
      multiplier   = 10'd1023;
      addend       = 10'd1023;
      in_valid     = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_state: out_valid=%b product=%0d in_ready=%b busy=%b, need 0 0 1 0",
                  out_valid, product, in_ready, busy);
      end
      for (int i = 0; i < 15; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_dropped cyc=%0d: out_valid=%b, need 0", i, out_valid);
         end
      end
      do_op(10'd12, 10'd12, 10'd0, lat, p);
      n_cmp++;
      if (lat !== 10 || p !== 20'd144) begin
         n_err++;
         $display("FAIL rstmid_next: latency=%0d product=%0d, need 10 144", lat, p);
      end
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_max();
      test_zero();
      test_roundtrip();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Iterative shift-add unsigned multiply-accumulate: product = multiplicand * multiplier + addend.
- Pairs with the pipelined divider as its inverse. Feeding it (quotient, divisor, remainder) rebuilds the 2*WIDTH dividend.
- Used for divide round-trip checking and for recomposing scaled values on the datapath.
- valid/ready handshake on both sides; one operation in flight; fixed latency.

Parameters:
- WIDTH, 10, operand width in bits. Product is 2*WIDTH bits. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- multiplicand  input  WIDTH  unsigned operand A.
- multiplier  input  WIDTH  unsigned operand B.
- addend  input  WIDTH  unsigned operand C, zero-extended.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  A*B+C.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset applies when rst_n=0 at a clk edge. Reset values:
  - state=IDLE.
  - out_valid=0, product=0, busy=0.
  - internal acc, shifted-multiplicand and shifted-multiplier registers cleared.
- Reset has priority over all other events. Reset mid-RUN or in DONE aborts the operation and drops any pending result; no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T: latch mcand={WIDTH'0,A}, mplier=B, acc={WIDTH'0,C}, cnt=0. Go to RUN.
  - RUN: in_ready=0. Each edge: if mplier[0], acc+=mcand (2*WIDTH-bit add). Then mcand<<=1, mplier>>=1, cnt++. After the edge with cnt==WIDTH-1, go to DONE and load product=final acc.
  - DONE: out_valid=1; product is held stable. On out_valid&&out_ready go to IDLE, out_valid=0.
- Timing:
  - Exactly WIDTH RUN iterations, with no early termination on mplier==0.
  - out_valid rises after edge T+WIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH runs, handoff, back to IDLE. in_ready is not asserted in the same cycle as the handoff.
- Width rule: max result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so it always fits in 2*WIDTH bits. No overflow output; no carry is lost.
- Operand inputs may change freely after the acceptance edge; only the latched copies are used.
- in_valid in RUN/DONE is ignored (not accepted, not queued).
- out_ready in IDLE/RUN has no effect.
- busy = (state != IDLE).
- Zero operands need no special case (A=0 or B=0 gives product=C, same latency).

Test Plan:
- Reset then idle, WIDTH=10: in_ready=1, out_valid=0, product=0, busy=0 held indefinitely with in_valid=0.
- A=1023, B=1023, C=1023, out_ready=1 -> out_valid exactly 10 cycles after acceptance, product=0xFFC00 (1047552), then IDLE.
- A=0, B=517, C=5 -> product=5 with the same 10-cycle latency. Then A=37, B=0, C=0 -> product=0.
- Divider round trip: A=7 (quotient), B=100 (divisor), C=3 (remainder) -> product=703. Random 1000-vector sweep checks product == A*B+C against a reference model.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready=0, new in_valid ignored. out_ready=1 -> handoff, in_ready=1 the next cycle.
- Reset mid-operation: rst_n=0 at cycle 4 of RUN -> next cycle out_valid=0, product=0, in_ready=1. A following operation A=12, B=12, C=0 -> product=144.
